// File: rtl/score_digit_arbiter.sv
// Shares one stacked 10-glyph digit ROM among the four score windows of the Pong screen.
// Latency: x/y/blank to pix_rgb/pix_on/blank_d is 2+ROM_LAT clocks; rom_addr is registered 1 clock after x/y.
// No backpressure: one ROM access and one pixel per clock, never stalls.
module score_digit_arbiter #(
  parameter int X_TENS_1     = 215,
  parameter int X_ONES_1     = 260,
  parameter int X_TENS_2     = 390,
  parameter int X_ONES_2     = 435,
  parameter int Y_POS        = 10,
  parameter int DIG_W        = 55,
  parameter int DIG_H        = 75,
  parameter int ROM_LAT      = 1,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        clk25,
  input  logic        reset_n,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        blank,
  input  logic [3:0]  score_1_tens,
  input  logic [3:0]  score_1_ones,
  input  logic [3:0]  score_2_tens,
  input  logic [3:0]  score_2_ones,
  output logic [15:0] rom_addr,
  input  logic [8:0]  rom_q,
  output logic [8:0]  pix_rgb,
  output logic        pix_on,
  output logic        blank_d
);

  localparam int          BW    = $clog2(BLINK_FRAMES + 1);
  localparam logic [15:0] GLYPH = 16'(DIG_W * DIG_H);
  localparam logic [15:0] ROW   = 16'(DIG_W);
  localparam logic [10:0] W     = 11'(DIG_W);
  localparam logic [10:0] Y_LO  = 11'(Y_POS);
  localparam logic [10:0] Y_HI  = 11'(Y_POS + DIG_H);
  localparam logic [10:0] X_LO [4] = '{11'(X_TENS_1), 11'(X_ONES_1), 11'(X_TENS_2), 11'(X_ONES_2)};

  logic [3:0]    score [4];
  logic [3:0]    shadow [4];
  logic [BW-1:0] blink_cnt [4];
  logic          frame_start;
  logic [10:0]   xe, ye;
  logic [3:0]    hit;
  logic          any_hit;
  logic [1:0]    sel;
  logic [10:0]   off_x, off_y;
  logic [15:0]   addr_c;
  logic          vis_c;
  logic [ROM_LAT:0] vis_p, blank_p;
  logic          show;

  assign score[0]    = score_1_tens;
  assign score[1]    = score_1_ones;
  assign score[2]    = score_2_tens;
  assign score[3]    = score_2_ones;
  assign frame_start = (x == 10'd0) && (y == 10'd0);
  assign xe          = {1'b0, x};
  assign ye          = {1'b0, y};

  // Snapshot live scores once per frame and restart the blink window of any digit that changed
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        shadow[i]    <= '0;
        blink_cnt[i] <= '0;
      end
    end else if (frame_start) begin
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= score[i];
        if (score[i] != shadow[i])
          blink_cnt[i] <= BW'(BLINK_FRAMES);
        else if (blink_cnt[i] != '0)
          blink_cnt[i] <= blink_cnt[i] - BW'(1);
      end
    end
  end

  // Window hit tests for the current pixel
  always_comb begin
    hit = '0;
    for (int i = 0; i < 4; i++)
      hit[i] = !blank && (xe >= X_LO[i]) && (xe < X_LO[i] + W) && (ye >= Y_LO) && (ye < Y_HI);
  end

  // Lowest window index wins where windows overlap; form the glyph address and visibility
  always_comb begin
    any_hit = |hit;
    sel     = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (hit[i]) sel = 2'(i);
    off_x  = xe - X_LO[sel];
    off_y  = ye - Y_LO;
    addr_c = ({12'd0, shadow[sel]} * GLYPH) + ({5'd0, off_y} * ROW) + {5'd0, off_x};
    vis_c  = any_hit && (shadow[sel] <= 4'd9) && !blink_cnt[sel][3];
  end

  // Stage 1 address register (held when nothing is drawn) plus vis/blank delay line tracking the ROM
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr <= '0;
      vis_p    <= '0;
      blank_p  <= '0;
    end else begin
      if (vis_c) rom_addr <= addr_c;
      vis_p   <= {vis_p[ROM_LAT-1:0], vis_c};
      blank_p <= {blank_p[ROM_LAT-1:0], blank};
    end
  end

  // Colour 0 in the ROM is transparent
  assign show = vis_p[ROM_LAT] && (rom_q != 9'd0);

  // Output register aligned with blank_d
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      pix_on  <= 1'b0;
      pix_rgb <= '0;
      blank_d <= 1'b0;
    end else begin
      pix_on  <= show;
      pix_rgb <= show ? rom_q : 9'd0;
      blank_d <= blank_p[ROM_LAT];
    end
  end

endmodule

// File: tb/tb_score_digit_arbiter.sv
// Directed bench for score_digit_arbiter: a ROM_LAT=1 and a ROM_LAT=2 instance share one stimulus.
module tb_score_digit_arbiter;

  logic clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  logic        reset_n;
  logic [9:0]  x, y;
  logic        blank;
  logic [3:0]  s1t, s1o, s2t, s2o;
  logic [15:0] addr1, addr2;
  logic [8:0]  q1, q2, q2a, rgb1, rgb2;
  logic        on1, on2, bd1, bd2;
  logic        zero_mode;

  int checks = 0;
  int fails  = 0;

  score_digit_arbiter #(.ROM_LAT(1)) dut1 (
    .clk25(clk25), .reset_n(reset_n), .x(x), .y(y), .blank(blank),
    .score_1_tens(s1t), .score_1_ones(s1o), .score_2_tens(s2t), .score_2_ones(s2o),
    .rom_addr(addr1), .rom_q(q1), .pix_rgb(rgb1), .pix_on(on1), .blank_d(bd1));

  score_digit_arbiter #(.ROM_LAT(2)) dut2 (
    .clk25(clk25), .reset_n(reset_n), .x(x), .y(y), .blank(blank),
    .score_1_tens(s1t), .score_1_ones(s1o), .score_2_tens(s2t), .score_2_ones(s2o),
    .rom_addr(addr2), .rom_q(q2), .pix_rgb(rgb2), .pix_on(on2), .blank_d(bd2));

  // ROM contents model: arbitrary nonzero-ish pattern, or all-transparent
  function automatic logic [8:0] romfn(input logic [15:0] a, input logic z);
    return z ? 9'd0 : (a[8:0] ^ 9'h0AA);
  endfunction

  always @(posedge clk25) begin
    q1  <= romfn(addr1, zero_mode);
    q2a <= romfn(addr2, zero_mode);
    q2  <= q2a;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic idle();
    x = 10'd700; y = 10'd500; blank = 1'b1;
  endtask

  // Called just after a negedge; drives (0,0) for one cycle
  task automatic frame();
    x = 10'd0; y = 10'd0; blank = 1'b1;
    @(negedge clk25);
    idle();
  endtask

  // Called just after a negedge; one pixel, then idle. Checks t+1 address, t+3 (lat1) and t+4 (lat2) outputs.
  task automatic apply(input string tag, input logic [9:0] vx, input logic [9:0] vy,
                       input logic vb, input logic [15:0] ea, input logic ev);
    logic [8:0] d;
    logic       eon;
    d   = romfn(ea, zero_mode);
    eon = ev && (d != 9'd0);
    x = vx; y = vy; blank = vb;
    @(negedge clk25);
    chk({tag, " addr1"}, 32'(addr1), 32'(ea));
    chk({tag, " addr2"}, 32'(addr2), 32'(ea));
    idle();
    @(negedge clk25);
    @(negedge clk25);
    chk({tag, " on1"},  32'(on1),  32'(eon));
    chk({tag, " rgb1"}, 32'(rgb1), eon ? 32'(d) : 32'd0);
    chk({tag, " bd1"},  32'(bd1),  32'(vb));
    @(negedge clk25);
    chk({tag, " on2"},  32'(on2),  32'(eon));
    chk({tag, " rgb2"}, 32'(rgb2), eon ? 32'(d) : 32'd0);
    chk({tag, " bd2"},  32'(bd2),  32'(vb));
  endtask

  typedef struct {
    logic [9:0]  vx;
    logic [9:0]  vy;
    logic        vb;
    logic [15:0] ea;
    logic        ev;
  } vec_t;

  vec_t tbl [14];
  logic hist [256];

  initial begin
    // scores 2,7,12,4 after the first frame start
    tbl[0]  = '{10'd215, 10'd10, 1'b0, 16'd8250,  1'b1};
    tbl[1]  = '{10'd262, 10'd20, 1'b0, 16'd8847,  1'b1};  // overlap: window 0 owns
    tbl[2]  = '{10'd270, 10'd20, 1'b0, 16'd29435, 1'b1};
    tbl[3]  = '{10'd314, 10'd84, 1'b0, 16'd32999, 1'b1};  // far corner of window 1
    tbl[4]  = '{10'd315, 10'd84, 1'b0, 16'd32999, 1'b0};  // just right of window 1
    tbl[5]  = '{10'd214, 10'd10, 1'b0, 16'd32999, 1'b0};  // just left of window 0
    tbl[6]  = '{10'd390, 10'd30, 1'b0, 16'd32999, 1'b0};  // score 12 suppressed
    tbl[7]  = '{10'd445, 10'd10, 1'b0, 16'd16510, 1'b1};
    tbl[8]  = '{10'd489, 10'd9,  1'b0, 16'd16510, 1'b0};  // above windows
    tbl[9]  = '{10'd489, 10'd85, 1'b0, 16'd16510, 1'b0};  // below windows
    tbl[10] = '{10'd489, 10'd84, 1'b0, 16'd20624, 1'b1};
    tbl[11] = '{10'd220, 10'd40, 1'b1, 16'd20624, 1'b0};  // blank inside window
    tbl[12] = '{10'd440, 10'd50, 1'b0, 16'd20624, 1'b0};  // overlap owned by suppressed window 2
    tbl[13] = '{10'd445, 10'd50, 1'b0, 16'd18710, 1'b1};

    reset_n = 1'b0; zero_mode = 1'b0;
    s1t = 4'd0; s1o = 4'd0; s2t = 4'd0; s2o = 4'd0;
    idle();
    repeat (3) @(negedge clk25);
    chk("rst addr1", 32'(addr1), 32'd0);
    chk("rst on1",   32'(on1),   32'd0);
    chk("rst rgb1",  32'(rgb1),  32'd0);
    chk("rst bd1",   32'(bd1),   32'd0);
    chk("rst on2",   32'(on2),   32'd0);
    chk("rst bd2",   32'(bd2),   32'd0);
    reset_n = 1'b1;
    @(negedge clk25);

    // shadows are 0 before any frame start: glyph 0
    apply("pre_frame", 10'd230, 10'd15, 1'b0, 16'd290, 1'b1);

    s1t = 4'd2; s1o = 4'd7; s2t = 4'd12; s2o = 4'd4;
    frame();
    for (int i = 0; i < 14; i++)
      apply($sformatf("tbl%0d", i), tbl[i].vx, tbl[i].vy, tbl[i].vb, tbl[i].ea, tbl[i].ev);

    s1t = 4'd3;
    frame();
    apply("tens3", 10'd215, 10'd10, 1'b0, 16'd12375, 1'b1);

    // asynchronous reset mid-stream while window 0 is being drawn
    x = 10'd215; y = 10'd10; blank = 1'b0;
    repeat (4) @(negedge clk25);
    chk("pre_rst on1",  32'(on1),  32'd1);
    chk("pre_rst rgb1", 32'(rgb1), 32'(romfn(16'd12375, 1'b0)));
    #5 reset_n = 1'b0;
    #1;
    chk("arst on1",   32'(on1),   32'd0);
    chk("arst rgb1",  32'(rgb1),  32'd0);
    chk("arst addr1", 32'(addr1), 32'd0);
    chk("arst bd1",   32'(bd1),   32'd0);
    chk("arst on2",   32'(on2),   32'd0);
    @(negedge clk25);
    reset_n = 1'b1;
    @(negedge clk25);
    chk("rel addr1", 32'(addr1), 32'd0);
    @(negedge clk25);
    chk("rel on1 early", 32'(on1), 32'd0);
    @(negedge clk25);
    chk("rel on1",  32'(on1),  32'd1);
    chk("rel rgb1", 32'(rgb1), 32'(romfn(16'd0, 1'b0)));
    idle();
    @(negedge clk25);

    // let every blink counter run out
    repeat (34) frame();

    // mid-frame change is invisible until the next frame start
    s2o = 4'd5;
    apply("midframe", 10'd445, 10'd10, 1'b0, 16'd16510, 1'b1);

    begin
      logic [15:0] last;
      int          cnt;
      logic        v;
      last = 16'd16510;
      for (int k = 1; k <= 34; k++) begin
        frame();
        cnt = (k <= 33) ? 33 - k : 0;
        v   = ((cnt & 8) == 0);
        if (v) last = 16'd20635;
        apply($sformatf("blink%0d", k), 10'd445, 10'd10, 1'b0, last, v);
      end
    end

    // transparent ROM colour inside a visible window
    zero_mode = 1'b1;
    repeat (3) @(negedge clk25);
    apply("zero_q", 10'd445, 10'd50, 1'b0, 16'd22835, 1'b1);
    zero_mode = 1'b0;

    // random sweep: blank_d tracks blank by 3 (lat1) and 4 (lat2) clocks
    for (int k = 0; k < 200; k++) begin
      if (k >= 3) chk($sformatf("sweep bd1 %0d", k), 32'(bd1), 32'(hist[k-3]));
      if (k >= 4) chk($sformatf("sweep bd2 %0d", k), 32'(bd2), 32'(hist[k-4]));
      x     = 10'($urandom_range(1, 799));
      y     = 10'($urandom_range(0, 524));
      blank = 1'($urandom_range(0, 1));
      hist[k] = blank;
      @(negedge clk25);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
